// File: rtl/feedback_accum_mc_pkg.sv
// Shared types, saturation limits and clamp helper for the multi-channel leaky integrator.
package feedback_accum_mc_types;

  localparam int DATA_W = 8;
  localparam int CHAN_W = 2;

  typedef struct packed {
    logic [CHAN_W-1:0]        chan;
    logic signed [DATA_W-1:0] data;
  } result_t;

  function automatic logic [CHAN_W+DATA_W-1:0] to_lv(input result_t r);
    return {r.chan, r.data};
  endfunction

  function automatic longint sat_hi(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  localparam longint SAT_MAX = sat_hi(DATA_W);
  localparam longint SAT_MIN = sat_lo(DATA_W);

  function automatic longint sat_clamp(input longint sum, input int width);
    if (sum > sat_hi(width)) return sat_hi(width);
    if (sum < sat_lo(width)) return sat_lo(width);
    return sum;
  endfunction

endpackage

// File: rtl/feedback_accum_mc_dp.sv
// Combinational datapath: y = sat(data + ((coef * state) >>> SHIFT)), plus a saturation indicator.
module feedback_accum_dp
  import feedback_accum_mc_types::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 7
) (
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [WIDTH-1:0]  state,
  input  logic signed [WIDTH-1:0]  data,
  output logic signed [WIDTH-1:0]  result,
  output logic                     sat
);

  localparam int P_W = WIDTH + COEF_W;
  localparam int S_W = P_W + 1;

  logic signed [P_W-1:0] product;
  logic signed [P_W-1:0] fb;
  logic signed [S_W-1:0] sum;
  longint                sum_wide;
  longint                clamped;

  always_comb begin
    product  = P_W'(coef) * P_W'(state);
    // Arithmetic shift floors toward minus infinity, which is the intended leak behaviour.
    fb       = product >>> SHIFT;
    sum      = S_W'(data) + S_W'(fb);
    sum_wide = 64'(sum);
    clamped  = sat_clamp(sum_wide, WIDTH);
    result   = clamped[WIDTH-1:0];
    sat      = (clamped != sum_wide);
  end

endmodule

// File: rtl/feedback_accum_mc.sv
// Time-multiplexed multi-channel leaky integrator with one output register and valid/ready handshakes.
module feedback_accum_mc
  import feedback_accum_mc_types::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int COEF_W   = 8,
  parameter int SHIFT    = 7,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic signed [COEF_W-1:0] coef,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_chan,
  output logic signed [WIDTH-1:0]  out_data,
  output logic                     sat_flag
);

  logic signed [WIDTH-1:0] state [CHANNELS];
  logic signed [WIDTH-1:0] cur_state;
  logic signed [WIDTH-1:0] dp_result;
  logic                    dp_sat;
  logic                    accept;
  logic                    in_range;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_range = (32'(in_chan) < CHANNELS);

  // A coincident clear means the accepted sample sees a zeroed state.
  always_comb begin
    cur_state = '0;
    if (!clear && in_range) cur_state = state[in_chan];
  end

  feedback_accum_dp #(
    .WIDTH  (WIDTH),
    .COEF_W (COEF_W),
    .SHIFT  (SHIFT)
  ) u_dp (
    .coef   (coef),
    .state  (cur_state),
    .data   (in_data),
    .result (dp_result),
    .sat    (dp_sat)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < CHANNELS; i++) state[i] <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (clear) begin
        for (int i = 0; i < CHANNELS; i++) state[i] <= '0;
        sat_flag <= 1'b0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_chan  <= in_chan;
        // Out-of-range channels still produce a (zero) result but never touch state.
        if (in_range) begin
          state[in_chan] <= dp_result;
          out_data       <= dp_result;
          if (dp_sat) sat_flag <= 1'b1;
        end else begin
          out_data <= '0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_feedback_accum_mc.sv
// Self-checking bench for feedback_accum_mc: directed scenarios plus randomized traffic vs. an arithmetic model.
module tb_feedback_accum_mc;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] coef = '0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_chan = '0;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [1:0]        out_chan;
  logic signed [7:0] out_data;
  logic              sat_flag;

  int vectors = 0;
  int miscompares = 0;

  int m_state [4];
  bit m_sat;

  feedback_accum_mc #(
    .WIDTH(8), .COEF_W(8), .SHIFT(7), .CHANNELS(4)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .coef            (coef),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_chan         (in_chan),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_chan        (out_chan),
    .out_data        (out_data),
    .sat_flag        (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_state[i] = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_accept(input int ch, input int x, input int c, input bit clr, output int y);
    int raw;
    if (clr) model_reset();
    raw = x + floor_div(c * m_state[ch], 128);
    y = (raw > 127) ? 127 : (raw < -128) ? -128 : raw;
    m_state[ch] = y;
    if (y != raw) m_sat = 1'b1;
  endtask

  task automatic send(input int ch, input int x, input int c, input bit clr, output int y);
    in_chan  = 2'(ch);
    in_data  = 8'(x);
    coef     = 8'(c);
    clear    = clr;
    in_valid = 1'b1;
    model_accept(ch, x, c, clr, y);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== 8'sd0 || sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b chan=%0d data=%0d sat=%b, expected 0/0/0/0",
               out_valid, out_chan, out_data, sat_flag);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int exp_vals [3] = '{10, 15, 17};
    int y;
    for (int i = 0; i < 3; i++) begin
      send(0, 10, 64, 1'b0, y);
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'(exp_vals[i])) begin
        miscompares++;
        $display("FAIL basic[%0d]: got valid=%b chan=%0d data=%0d, expected 1/0/%0d",
                 i, out_valid, out_chan, out_data, exp_vals[i]);
      end
    end
    vectors++;
    if (sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_sat: got %b expected 0", sat_flag);
    end
  endtask

  task automatic test_interleave();
    int chs [4]      = '{0, 1, 0, 1};
    int xs [4]       = '{10, -20, 10, -20};
    int exp_vals [4] = '{10, -20, 15, -30};
    int y;
    for (int i = 0; i < 4; i++) begin
      send(chs[i], xs[i], 64, i == 0, y);
      vectors++;
      if (out_chan !== 2'(chs[i]) || out_data !== 8'(exp_vals[i])) begin
        miscompares++;
        $display("FAIL interleave[%0d]: got chan=%0d data=%0d, expected %0d/%0d",
                 i, out_chan, out_data, chs[i], exp_vals[i]);
      end
    end
  endtask

  task automatic test_floor_shift();
    int xs [3]       = '{-1, 0, 0};
    int cs [3]       = '{0, 64, 0};
    int exp_vals [3] = '{-1, -1, 0};
    int y;
    for (int i = 0; i < 3; i++) begin
      send(2, xs[i], cs[i], i == 0, y);
      vectors++;
      if (out_data !== 8'(exp_vals[i])) begin
        miscompares++;
        $display("FAIL floor[%0d]: got %0d expected %0d", i, out_data, exp_vals[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int xs [5]       = '{120, 100, 0, -128, -100};
    int cs [5]       = '{0, 64, 0, 0, 127};
    int exp_vals [5] = '{120, 127, 0, -128, -128};
    bit exp_sat [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int y;
    for (int i = 0; i < 5; i++) begin
      send(3, xs[i], cs[i], i == 0, y);
      vectors++;
      if (out_data !== 8'(exp_vals[i]) || sat_flag !== exp_sat[i]) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got data=%0d sat=%b, expected %0d/%b",
                 i, out_data, sat_flag, exp_vals[i], exp_sat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int ya, yb;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2, 30, 0, 1'b0, ya);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'(ya)) begin
      miscompares++;
      $display("FAIL bp_first: got valid=%b data=%0d, expected 1/%0d", out_valid, out_data, ya);
    end
    in_chan  = 2'd2;
    in_data  = 8'sd40;
    coef     = 8'sd64;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'(ya)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b chan=%0d data=%0d, expected 1/2/%0d",
                 k, out_valid, out_chan, out_data, ya);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    model_accept(2, 40, 64, 1'b0, yb);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'(yb) || yb != 55) begin
      miscompares++;
      $display("FAIL bp_release_data: got valid=%b data=%0d, expected 1/55", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_dup: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_clear_accept();
    int y;
    send(3, 120, 0, 1'b0, y);
    send(3, 100, 64, 1'b0, y);
    send(1, 33, 0, 1'b0, y);
    send(0, 100, 0, 1'b0, y);
    vectors++;
    if (sat_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pre_sat: got %b expected 1", sat_flag);
    end
    send(0, 5, 64, 1'b1, y);
    vectors++;
    if (out_data !== 8'sd5 || sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_accept: got data=%0d sat=%b, expected 5/0", out_data, sat_flag);
    end
    send(0, 0, 64, 1'b0, y);
    vectors++;
    if (out_data !== 8'sd2) begin
      miscompares++;
      $display("FAIL clr_state_ch0: got %0d expected 2", out_data);
    end
    send(1, 0, 127, 1'b0, y);
    vectors++;
    if (out_data !== 8'sd0) begin
      miscompares++;
      $display("FAIL clr_state_ch1: got %0d expected 0", out_data);
    end
    send(3, 0, 127, 1'b0, y);
    vectors++;
    if (out_data !== 8'sd0) begin
      miscompares++;
      $display("FAIL clr_state_ch3: got %0d expected 0", out_data);
    end
  endtask

  task automatic test_random();
    int ch, x, c, y;
    bit clr;
    out_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ch  = int'($urandom_range(0, 3));
      x   = int'($urandom_range(0, 255)) - 128;
      c   = int'($urandom_range(0, 255)) - 128;
      clr = ($urandom_range(0, 15) == 0);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b expected 1", n, in_ready);
      end
      send(ch, x, c, clr, y);
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 2'(ch) || out_data !== 8'(y) || sat_flag !== m_sat) begin
        miscompares++;
        $display("FAIL rand[%0d]: got valid=%b chan=%0d data=%0d sat=%b, expected 1/%0d/%0d/%b",
                 n, out_valid, out_chan, out_data, sat_flag, ch, y, m_sat);
      end
    end
  endtask

  task automatic test_async_reset();
    int y;
    out_ready = 1'b0;
    send(1, 50, 0, 1'b0, y);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: got valid=%b expected 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0 || sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_immediate: got valid=%b data=%0d sat=%b, expected 0/0/0",
               out_valid, out_data, sat_flag);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1, 7, 64, 1'b0, y);
    vectors++;
    if (out_data !== 8'sd7) begin
      miscompares++;
      $display("FAIL arst_state_lost: got %0d expected 7", out_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_floor_shift();
    test_saturation();
    test_backpressure();
    test_clear_accept();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
